// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Instruction fetch front end. Keeps at most one outstanding
//                instruction-memory request and a single-entry output buffer
//                toward decode. Handles branch redirects, squashing a response
//                that belongs to a redirected-away request.
//  Ports       : clk, reset            - clock, async active-high reset
//                branch_taken/target   - redirect from branch stage
//                imem_req/addr/gnt     - request channel to instruction memory
//                imem_rvalid/rdata     - response channel from memory
//                id_valid/ready/pc/ir  - handshake toward decode
//                fetch_err             - sticky: response with nothing pending
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_ir,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr_pend;
    logic        r_buf_valid;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_ir;
    logic        r_squash;
    logic        r_fetch_err;
    // Low during reset and until the first clock edge after release, so the
    // request appears on that edge rather than the instant reset drops.
    logic        r_run;

    logic        w_xfer;

    assign imem_req  = r_run && (r_state == S_REQ);
    assign imem_addr = r_pc;
    // A redirect cycle must never hand decode a stale instruction.
    assign id_valid  = r_buf_valid && !branch_taken;
    assign id_pc     = r_buf_pc;
    assign id_ir     = r_buf_ir;
    assign fetch_err = r_fetch_err;
    assign w_xfer    = id_valid && id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_addr_pend <= 32'd0;
            r_buf_valid <= 1'b0;
            r_buf_pc    <= 32'd0;
            r_buf_ir    <= 32'd0;
            r_squash    <= 1'b0;
            r_fetch_err <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            // Only WAIT expects a response; anything else is a protocol fault.
            if (imem_rvalid && (r_state != S_WAIT)) begin
                r_fetch_err <= 1'b1;
            end
            unique case (r_state)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        r_state     <= S_WAIT;
                        r_addr_pend <= r_pc;
                        if (branch_taken) begin
                            // Granted request is already stale: drop its reply.
                            r_pc     <= branch_target;
                            r_squash <= 1'b1;
                        end else begin
                            r_pc <= r_pc + PC_STEP;
                        end
                    end else if (branch_taken) begin
                        r_pc <= branch_target;
                    end
                end
                S_WAIT: begin
                    if (branch_taken) begin
                        r_pc <= branch_target;
                    end
                    if (imem_rvalid) begin
                        if (r_squash || branch_taken) begin
                            r_squash <= 1'b0;
                            r_state  <= S_REQ;
                        end else begin
                            r_buf_ir    <= imem_rdata;
                            r_buf_pc    <= r_addr_pend;
                            r_buf_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (branch_taken) begin
                        // A repeated redirect keeps the single pending discard.
                        r_squash <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        r_pc        <= branch_target;
                        r_buf_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end else if (w_xfer) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0, is the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 32'd1, is the sequential PC increment (word addressing, matching pc_in + rd branch targets).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 branch_taken  input  1  redirect request from the branch stage (its warn_signal).
REQ-006 branch_target  input  32  redirect PC from the branch stage (its out); sampled only when branch_taken=1.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-009 imem_gnt  input  1  memory accepts the request in a cycle where imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid, one response per granted request.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-012 id_valid  output  1  instruction available to decode.
REQ-013 id_ready  input  1  decode accepts; transfer occurs when id_valid && id_ready.
REQ-014 id_pc  output  32  PC of the presented instruction.
REQ-015 id_ir  output  32  presented instruction word.
REQ-016 fetch_err  output  1  sticky error flag: imem_rvalid arrived with no outstanding request.

Function
REQ-017 The block SHALL keep at most one outstanding memory request and a single-entry output buffer (buf_valid, buf_pc, buf_ir).
REQ-018 FSM states SHALL be REQ, WAIT and HOLD.
- REQ: imem_req=1, imem_addr=pc.
- WAIT: granted, awaiting imem_rvalid.
- HOLD: buffer full, awaiting decode.
REQ-019 REQ -> WAIT on imem_gnt=1; pc SHALL then advance by PC_STEP and addr_pend SHALL capture the granted address.
REQ-020 WAIT -> HOLD on imem_rvalid=1 with no squash pending; buf_ir<=imem_rdata, buf_pc<=addr_pend, buf_valid<=1.
REQ-021 HOLD -> REQ on a decode transfer; buf_valid<=0 at that edge.
- A new request SHALL NOT be issued in the same cycle as the transfer.
REQ-022 id_valid SHALL equal buf_valid && !branch_taken (combinational gating), so no transfer occurs in a redirect cycle.
- id_pc=buf_pc; id_ir=buf_ir.
REQ-023 Redirect (branch_taken=1) SHALL set pc<=branch_target and buf_valid<=0, with state handling as follows.
- REQ with imem_gnt=0: stay in REQ; imem_addr SHALL show branch_target from the next cycle.
- REQ with imem_gnt=1 in the same cycle: go to WAIT with squash<=1; pc<=branch_target (no PC_STEP added).
- WAIT: set squash<=1 and stay in WAIT. If imem_rvalid=1 in the same cycle, discard the data and go to REQ with squash<=0.
- HOLD: go to REQ.
REQ-024 In WAIT with squash=1, the next imem_rvalid SHALL be discarded, clear squash, and move to REQ with no buffer write.
REQ-025 A second redirect while squash=1 SHALL update pc only; squash stays 1 and only one response is discarded.
REQ-026 imem_rvalid outside WAIT SHALL be ignored and SHALL set fetch_err<=1 until reset.
REQ-027 pc arithmetic SHALL be unsigned 32-bit modulo 2^32: 32'hFFFFFFFF + 1 wraps to 0 with no flag.
REQ-028 imem_req SHALL be a registered-state decode (high exactly in REQ) and SHALL NOT depend combinationally on imem_gnt.
REQ-029 Minimum steady-state fetch interval SHALL be 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and id_ready=1.

Reset
REQ-030 Asserting reset SHALL immediately force the following values, regardless of clk.
- state=REQ, pc=RESET_PC, buf_valid=0, squash=0, fetch_err=0, addr_pend=0, buf_pc=0, buf_ir=0.
REQ-031 While reset=1, outputs SHALL read: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_ir=0, fetch_err=0.
REQ-032 On the first rising clk edge after deassertion, imem_req=1 with imem_addr=RESET_PC.
REQ-033 Reset asserted mid-request or mid-WAIT SHALL abandon the transaction; any later imem_rvalid for it is treated per REQ-026.

Verification
REQ-034 Sequential fetch: gnt and rvalid each one cycle after request, id_ready=1.
- Decode receives (pc,ir) = (0,A), (1,B), (2,C) at 3-cycle spacing.
REQ-035 Backpressure: id_ready=0 for 5 cycles with buffer full.
- id_valid held, id_pc/id_ir stable, imem_req=0 throughout.
REQ-036 Redirect in WAIT: branch_taken=1, branch_target=0x40 while awaiting rvalid.
- Returned word is discarded; next imem_addr=0x40; decode never sees the old PC.
REQ-037 Redirect coincident with imem_gnt for addr 5, target 0x10.
- One response discarded, then a request to 0x10; id_pc sequence continues 0x10, 0x11.
REQ-038 Wrap-around: RESET_PC=32'hFFFFFFFF.
- imem_addr sequence is FFFFFFFF, 00000000.
REQ-039 Fault and reset: imem_rvalid pulse in REQ sets fetch_err=1; reset asserted mid-WAIT.
- All outputs at reset values within the same cycle, fetch_err=0.
